// File: rtl/wb_uart.sv
// -----------------------------------------------------------------------------
// wb_uart: Wishbone B4 classic slave with an 8N1 UART.
//
// A TX FIFO feeds a serialiser. The RX deserialiser delivers each byte into a
// single holding register. A programmable divider sets the bit time to
// CLKDIV+1 clocks. A level interrupt is raised while any RX status bit is set.
//
// Register map (word offset adr[3:2]):
//   0 TXDATA  W: push dat[7:0] when sel[0]; dropped if the FIFO is full. R: 0
//   1 RXDATA  R: {24'b0, rx_byte}, clears rx_valid.      W: ignored
//   2 STATUS  R: {frame_err, rx_overrun, rx_valid, tx_busy, tx_empty, tx_full}
//             W (sel[0]): bit4/bit5 write-1-to-clear
//   3 CLKDIV  R/W [15:0], byte lanes sel[1:0]; a zero result becomes 1
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_wbs_cyc/stb/we     Wishbone cycle, strobe, write enable
//   i_wbs_sel[3:0]       byte lanes
//   i_wbs_adr[31:0]      address (only [3:2] decoded)
//   i_wbs_dat[31:0]      write data
//   o_wbs_ack            registered acknowledge, one cycle after the access
//   o_wbs_dat[31:0]      read data, valid with ack and 0 otherwise
//   i_uart_rx            asynchronous serial input, idle high
//   o_uart_tx            serial output, idle high
//   o_irq                level interrupt, active high
// -----------------------------------------------------------------------------
module wb_uart #(
   parameter int unsigned TX_DEPTH    = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wbs_cyc,
   input  logic        i_wbs_stb,
   input  logic        i_wbs_we,
   input  logic [3:0]  i_wbs_sel,
   input  logic [31:0] i_wbs_adr,
   input  logic [31:0] i_wbs_dat,
   output logic        o_wbs_ack,
   output logic [31:0] o_wbs_dat,
   input  logic        i_uart_rx,
   output logic        o_uart_tx,
   output logic        o_irq
);

   localparam int unsigned AW = $clog2(TX_DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ---------------------------------------------------------------- bus
   logic        access;
   logic        ack_q, ack_d;
   logic [1:0]  reg_sel;
   logic        bus_wr, bus_rd;
   logic [31:0] rdata;

   assign access  = i_wbs_cyc & i_wbs_stb;
   assign ack_d   = access & ~ack_q;
   assign reg_sel = i_wbs_adr[3:2];
   // Side effects fire only in the cycle ack is high, so each access acts once.
   assign bus_wr  = ack_q & access & i_wbs_we;
   assign bus_rd  = ack_q & access & ~i_wbs_we;

   // ---------------------------------------------------------------- state
   logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [7:0]   fifo_mem_q [TX_DEPTH];
   logic         fifo_full, fifo_empty, push, pop;

   logic [15:0]  div_q, div_d;

   tx_state_t    tx_state_q, tx_state_d;
   logic [15:0]  tx_cnt_q, tx_cnt_d;
   logic [2:0]   tx_bit_q, tx_bit_d;
   logic [7:0]   tx_shift_q, tx_shift_d;
   logic         tx_q, tx_d;

   logic         rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_t    rx_state_q, rx_state_d;
   logic [15:0]  rx_cnt_q, rx_cnt_d;
   logic [2:0]   rx_bit_q, rx_bit_d;
   logic [7:0]   rx_shift_q, rx_shift_d;
   logic [7:0]   rx_byte_q, rx_byte_d;
   logic         rx_valid_q, rx_valid_d;
   logic         rx_ovr_q, rx_ovr_d;
   logic         frame_err_q, frame_err_d;
   logic         irq_q, irq_d;
   logic         rx_load, rx_ferr_set, rx_rd, st_wr;

   logic [16:0]  div_inc;
   logic [15:0]  rx_half;

   logic         unused_ok;
   assign unused_ok = ^{i_wbs_adr[31:4], i_wbs_adr[1:0], i_wbs_dat[31:16],
                        i_wbs_sel[3:2], div_inc[0]};

   // ---------------------------------------------------------------- TX FIFO
   // Pointers carry one extra wrap bit: equal means empty, differing only in
   // the wrap bit means full.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push       = bus_wr & (reg_sel == 2'd0) & i_wbs_sel[0] & ~fifo_full;
   assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
   assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};

   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q[AW-1:0]] <= i_wbs_dat[7:0];
      end
   end

   // ---------------------------------------------------------------- CLKDIV
   always_comb begin
      logic [15:0] nv;
      nv    = div_q;
      div_d = div_q;
      if (bus_wr && reg_sel == 2'd3) begin
         if (i_wbs_sel[0]) nv[7:0]  = i_wbs_dat[7:0];
         if (i_wbs_sel[1]) nv[15:8] = i_wbs_dat[15:8];
         div_d = (nv == 16'd0) ? 16'd1 : nv;
      end
   end

   // ---------------------------------------------------------------- TX FSM
   // Each state lasts div_q+1 clocks; the counter is reloaded from div_q at
   // every bit boundary so a new divider applies from the next bit on.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      pop        = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               tx_shift_d = fifo_mem_q[rd_ptr_q[AW-1:0]];
               tx_cnt_d   = div_q;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_q == 16'd0) begin
               tx_cnt_d   = div_q;
               tx_bit_d   = 3'd0;
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == 16'd0) begin
               tx_cnt_d   = div_q;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == 16'd0) begin
               // Reload straight into START when data is waiting: no idle gap.
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  tx_shift_d = fifo_mem_q[rd_ptr_q[AW-1:0]];
                  tx_cnt_d   = div_q;
                  tx_state_d = TX_START;
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase

      case (tx_state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = tx_shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------- RX FSM
   // First sample lands half a bit after the synchronised falling edge.
   assign div_inc = {1'b0, div_q} + 17'd1;
   assign rx_half = div_inc[16:1] - 16'd1;

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_load     = 1'b0;
      rx_ferr_set = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_cnt_d   = rx_half;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt_q == 16'd0) begin
               if (rx_sync_q) begin
                  rx_state_d = RX_IDLE;   // start bit gone high again: glitch
               end else begin
                  rx_cnt_d   = div_q;
                  rx_bit_d   = 3'd0;
                  rx_state_d = RX_DATA;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == 16'd0) begin
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               rx_cnt_d   = div_q;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == 16'd0) begin
               if (rx_sync_q) rx_load     = 1'b1;
               else           rx_ferr_set = 1'b1;
               rx_state_d = RX_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- RX status
   assign rx_rd = bus_rd & (reg_sel == 2'd1);
   assign st_wr = bus_wr & (reg_sel == 2'd2) & i_wbs_sel[0];

   always_comb begin
      rx_byte_d   = rx_load ? rx_shift_q : rx_byte_q;
      // A load in the same cycle as an RXDATA read wins over the clear.
      rx_valid_d  = rx_load ? 1'b1 : (rx_rd ? 1'b0 : rx_valid_q);
      rx_ovr_d    = rx_ovr_q;
      frame_err_d = frame_err_q;
      if (st_wr && i_wbs_dat[4]) rx_ovr_d    = 1'b0;
      if (st_wr && i_wbs_dat[5]) frame_err_d = 1'b0;
      if (rx_load && rx_valid_q && !rx_rd) rx_ovr_d = 1'b1;
      if (rx_ferr_set) frame_err_d = 1'b1;
      irq_d = rx_valid_q | rx_ovr_q | frame_err_q;
   end

   // ---------------------------------------------------------------- read mux
   always_comb begin
      rdata = 32'd0;
      case (reg_sel)
         2'd1: rdata[7:0]  = rx_byte_q;
         2'd2: rdata[5:0]  = {frame_err_q, rx_ovr_q, rx_valid_q,
                              (tx_state_q != TX_IDLE), fifo_empty, fifo_full};
         2'd3: rdata[15:0] = div_q;
         default: rdata = 32'd0;
      endcase
   end

   assign o_wbs_ack = ack_q;
   assign o_wbs_dat = (ack_q && !i_wbs_we) ? rdata : 32'd0;
   assign o_uart_tx = tx_q;
   assign o_irq     = irq_q;

   // ---------------------------------------------------------------- registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ack_q       <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         div_q       <= DEFAULT_DIV;
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= 16'd0;
         tx_bit_q    <= 3'd0;
         tx_shift_q  <= 8'd0;
         tx_q        <= 1'b1;
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         rx_prev_q   <= 1'b1;
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= 16'd0;
         rx_bit_q    <= 3'd0;
         rx_shift_q  <= 8'd0;
         rx_byte_q   <= 8'd0;
         rx_valid_q  <= 1'b0;
         rx_ovr_q    <= 1'b0;
         frame_err_q <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         ack_q       <= ack_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         div_q       <= div_d;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         tx_q        <= tx_d;
         rx_meta_q   <= i_uart_rx;
         rx_sync_q   <= rx_meta_q;
         rx_prev_q   <= rx_sync_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         rx_byte_q   <= rx_byte_d;
         rx_valid_q  <= rx_valid_d;
         rx_ovr_q    <= rx_ovr_d;
         frame_err_q <= frame_err_d;
         irq_q       <= irq_d;
      end
   end

endmodule

// File: tb/tb_wb_uart.sv
// -----------------------------------------------------------------------------
// tb_wb_uart: self-checking bench for wb_uart. A TX line monitor decodes
// frames into a queue; RX frames are driven bit by bit and a small register
// model predicts RXDATA/STATUS/irq from the UART rules.
// -----------------------------------------------------------------------------
module tb_wb_uart;
   localparam int          TX_DEPTH    = 8;
   localparam logic [15:0] DEFAULT_DIV = 16'd867;
   localparam int          BIT         = 4;   // clocks per bit with CLKDIV=3

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [3:0]  wb_sel = 4'd0;
   logic [31:0] wb_adr = 32'd0, wb_wdat = 32'd0;
   logic        wb_ack;
   logic [31:0] wb_rdat;
   logic        uart_rx = 1'b1;
   logic        uart_tx;
   logic        irq;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;

   wb_uart #(.TX_DEPTH(TX_DEPTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wbs_cyc(wb_cyc), .i_wbs_stb(wb_stb), .i_wbs_we(wb_we),
      .i_wbs_sel(wb_sel), .i_wbs_adr(wb_adr), .i_wbs_dat(wb_wdat),
      .o_wbs_ack(wb_ack), .o_wbs_dat(wb_rdat),
      .i_uart_rx(uart_rx), .o_uart_tx(uart_tx), .o_irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // ---------------------------------------------------------------- checking
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------- bus
   task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
      int n;
      @(posedge clk); #1;
      check("idle_ack", 32'(wb_ack), 32'd0);
      check("idle_dat", wb_rdat, 32'd0);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = w;
      wb_adr = {28'd0, a, 2'b00}; wb_wdat = d; wb_sel = s;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!wb_ack && n < 8);
      check("ack_latency", n, 32'd1);
      r = wb_rdat;
      @(posedge clk); #1;
      check("ack_single", 32'(wb_ack), 32'd0);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      wb_xfer(1'b1, a, d, s, dummy);
   endtask

   task automatic wb_read(input logic [1:0] a, output logic [31:0] r);
      wb_xfer(1'b0, a, 32'd0, 4'hF, r);
   endtask

   // ---------------------------------------------------------------- TX monitor
   logic [7:0] tx_got[$];
   int         tx_start[$];
   int         tx_stop_bad = 0;
   bit         mon_en = 1'b0;

   initial begin : tx_monitor
      logic [7:0] b;
      int st;
      forever begin
         @(negedge clk);
         if (mon_en && uart_tx === 1'b0) begin
            st = cyc_cnt;
            repeat (BIT / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
               repeat (BIT) @(negedge clk);
               b[k] = uart_tx;
            end
            repeat (BIT) @(negedge clk);
            if (uart_tx !== 1'b1) tx_stop_bad++;
            tx_got.push_back(b);
            tx_start.push_back(st);
         end
      end
   end

   // ---------------------------------------------------------------- RX driver
   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         uart_rx = f[i];
         repeat (BIT - 1) @(negedge clk);
      end
      @(negedge clk);
      uart_rx = 1'b1;
   endtask

   // ---------------------------------------------------------------- RX model
   bit         m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
   logic [7:0] m_byte = 8'd0;

   task automatic model_frame(input logic [7:0] b, input logic good);
      if (good) begin
         if (m_valid) m_ovr = 1'b1;
         m_valid = 1'b1;
         m_byte  = b;
      end else begin
         m_ferr = 1'b1;
      end
   endtask

   function automatic logic [31:0] idle_status();
      return {26'd0, m_ferr, m_ovr, m_valid, 3'b010};
   endfunction

   // ---------------------------------------------------------------- stimulus
   initial begin : main
      logic [31:0] r, v;
      logic [3:0]  s;
      logic [15:0] m_div;
      logic [7:0]  b;
      logic        good;
      logic [9:0]  frame;
      logic [7:0]  wr_bytes[10];
      logic [7:0]  exp_q[$];
      int          occ, n, bad;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(uart_tx), 32'd1);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_ack", 32'(wb_ack), 32'd0);
      check("rst_dat", wb_rdat, 32'd0);
      rst_n = 1'b1;
      wb_read(2'd2, r); check("rst_status", r, 32'h02);
      wb_read(2'd3, r); check("rst_clkdiv", r, {16'd0, DEFAULT_DIV});
      wb_read(2'd1, r); check("rst_rxdata", r, 32'd0);
      wb_read(2'd0, r); check("rst_txdata", r, 32'd0);

      // CLKDIV lane writes, zero forced to 1
      m_div = DEFAULT_DIV;
      for (int i = 0; i < 5; i++) begin
         v = $urandom;
         s = 4'($urandom_range(15));
         if (i == 4) begin v = 32'd0; s = 4'h3; end
         wb_write(2'd3, v, s);
         if (s[0]) m_div[7:0]  = v[7:0];
         if (s[1]) m_div[15:8] = v[15:8];
         if (m_div == 16'd0) m_div = 16'd1;
         wb_read(2'd3, r);
         check("clkdiv_rw", r, {16'd0, m_div});
      end
      wb_write(2'd3, 32'd3, 4'h3);
      mon_en = 1'b1;

      // Read-only writes and a TXDATA write without sel[0] change nothing
      wb_write(2'd2, 32'hFF, 4'hE);
      wb_write(2'd1, 32'h55, 4'hF);
      wb_write(2'd0, 32'h77, 4'hE);
      wb_read(2'd2, r); check("ro_writes_status", r, 32'h02);

      // Single frame 0xA5: check every clock of the waveform
      wb_write(2'd0, 32'hA5, 4'h1);
      n = 0;
      while (uart_tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      check("tx_start_seen", 32'(uart_tx), 32'd0);
      frame = {1'b1, 8'hA5, 1'b0};
      bad = 0;
      for (int i = 0; i < 10 * BIT; i++) begin
         if (uart_tx !== frame[i / BIT]) bad++;
         @(negedge clk);
      end
      check("tx_wave_A5", bad, 32'd0);
      check("tx_idle_after", 32'(uart_tx), 32'd1);
      wb_read(2'd2, r); check("status_after_A5", r, 32'h02);
      check("mon_A5_count", tx_got.size(), 32'd1);
      tx_got.delete(); tx_start.delete();

      // Burst: the serialiser takes the first byte at once, then the FIFO
      // accepts TX_DEPTH bytes and drops the rest until the frame ends.
      exp_q.delete();
      occ = 0;
      for (int i = 0; i < 10; i++) begin
         wr_bytes[i] = 8'($urandom);
         if (i == 0) exp_q.push_back(wr_bytes[i]);
         else if (occ < TX_DEPTH) begin occ++; exp_q.push_back(wr_bytes[i]); end
      end
      for (int i = 0; i < 10; i++) begin
         wb_write(2'd0, {24'd0, wr_bytes[i]}, 4'h1);
         if (i == 8) begin
            wb_read(2'd2, r); check("burst_full", r, 32'h05);
         end
      end
      wb_read(2'd2, r); check("burst_drop_full", r, 32'h05);
      n = 0;
      while (tx_got.size() < exp_q.size() && n < 20 * 10 * BIT) begin @(negedge clk); n++; end
      check("burst_frames_timeout", 32'(tx_got.size() >= exp_q.size()), 32'd1);
      repeat (3 * 10 * BIT) @(negedge clk);
      check("burst_count", tx_got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < tx_got.size(); i++) begin
         check("burst_byte", {24'd0, tx_got[i]}, {24'd0, exp_q[i]});
         if (i > 0) check("burst_gapless", tx_start[i] - tx_start[i-1], 10 * BIT);
      end
      check("burst_stop_bits", tx_stop_bad, 32'd0);
      wb_read(2'd2, r); check("burst_done_status", r, 32'h02);

      // RX 0x3C
      send_rx(8'h3C, 1'b1);
      model_frame(8'h3C, 1'b1);
      repeat (3) @(negedge clk);
      check("rx_irq_set", 32'(irq), 32'd1);
      wb_read(2'd2, r); check("rx_status_valid", r, idle_status());
      wb_read(2'd1, r); check("rx_data_3C", r, {24'd0, m_byte});
      m_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("rx_irq_clear", 32'(irq), 32'd0);
      wb_read(2'd2, r); check("rx_status_clear", r, idle_status());

      // Overrun: two frames without reading
      for (int i = 0; i < 2; i++) begin
         b = 8'($urandom);
         send_rx(b, 1'b1);
         model_frame(b, 1'b1);
      end
      repeat (4) @(negedge clk);
      wb_read(2'd2, r); check("ovr_status", r, idle_status());
      wb_read(2'd1, r); check("ovr_rxdata", r, {24'd0, m_byte});
      m_valid = 1'b0;
      wb_write(2'd2, 32'h10, 4'h1);
      m_ovr = 1'b0;
      wb_read(2'd2, r); check("ovr_w1c", r, idle_status());

      // One-clock glitch is ignored
      @(negedge clk); uart_rx = 1'b0;
      @(negedge clk); uart_rx = 1'b1;
      repeat (12 * BIT) @(negedge clk);
      wb_read(2'd2, r); check("glitch_status", r, idle_status());

      // Stop bit low: frame error, rx_valid untouched
      send_rx(8'h81, 1'b0);
      model_frame(8'h81, 1'b0);
      repeat (4) @(negedge clk);
      wb_read(2'd2, r); check("ferr_status", r, idle_status());
      check("ferr_irq", 32'(irq), 32'd1);
      wb_write(2'd2, 32'h20, 4'h1);
      m_ferr = 1'b0;
      wb_read(2'd2, r); check("ferr_w1c", r, idle_status());

      // Random RX frames and register accesses against the model
      for (int i = 0; i < 8; i++) begin
         b    = 8'($urandom);
         good = ($urandom_range(3) != 0);
         send_rx(b, good);
         model_frame(b, good);
         repeat (4) @(negedge clk);
         case ($urandom_range(2))
            0: begin
               wb_read(2'd1, r); check("rand_rxdata", r, {24'd0, m_byte});
               m_valid = 1'b0;
            end
            1: begin
               wb_read(2'd2, r); check("rand_status", r, idle_status());
            end
            default: begin
               v = {26'd0, 2'($urandom_range(3)), 4'd0};
               wb_write(2'd2, v, 4'h1);
               if (v[4]) m_ovr  = 1'b0;
               if (v[5]) m_ferr = 1'b0;
            end
         endcase
         repeat (2) @(negedge clk);
         check("rand_irq", 32'(irq), 32'(m_valid | m_ovr | m_ferr));
         wb_read(2'd2, r); check("rand_status_end", r, idle_status());
      end

      // Reset in the middle of a TX frame
      for (int i = 0; i < 3; i++) wb_write(2'd0, 32'($urandom_range(255)), 4'h1);
      n = 0;
      while (uart_tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      check("rst_mid_start_seen", 32'(uart_tx), 32'd0);
      repeat (6) @(negedge clk);
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("rst_mid_tx", 32'(uart_tx), 32'd1);
      check("rst_mid_irq", 32'(irq), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
      wb_read(2'd2, r); check("rst_mid_status", r, 32'h02);
      wb_read(2'd3, r); check("rst_mid_clkdiv", r, {16'd0, DEFAULT_DIV});
      check("rst_mid_tx_idle", 32'(uart_tx), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
